// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the 3x3 systolic array sequencer.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StCapture} state_e;

  localparam int unsigned SaN       = 3;
  localparam int unsigned SaFeedCyc = 2 * SaN - 1;

  // Flat element index of (r, c) in a row-major 3x3 matrix.
  function automatic logic [3:0] elem_idx(input logic [1:0] r, input logic [1:0] c);
    return {2'b00, r} * 4'd3 + {2'b00, c};
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_sel.sv
// Picks the diagonally skewed row/column elements for feed step k.
module systolic_ctrl_skew_sel
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned data_size = 32
) (
  input  logic [3:0]             k,
  input  logic [9*data_size-1:0] a_mat,
  input  logic [9*data_size-1:0] b_mat,
  output logic [data_size-1:0]   a1,
  output logic [data_size-1:0]   a2,
  output logic [data_size-1:0]   a3,
  output logic [data_size-1:0]   b1,
  output logic [data_size-1:0]   b2,
  output logic [data_size-1:0]   b3
);

  logic [data_size-1:0] a_el  [9];
  logic [data_size-1:0] b_el  [9];
  logic [data_size-1:0] a_sel [SaN];
  logic [data_size-1:0] b_sel [SaN];
  logic [3:0]           d;

  for (genvar n = 0; n < 9; n++) begin : g_unpack
    assign a_el[n] = a_mat[n*data_size +: data_size];
    assign b_el[n] = b_mat[n*data_size +: data_size];
  end

  // Row i of A and column i of B both enter i cycles late.
  always_comb begin
    d = '0;
    for (int i = 0; i < int'(SaN); i++) begin
      a_sel[i] = '0;
      b_sel[i] = '0;
      d        = k - 4'(i);
      if (k >= 4'(i) && d <= 4'd2) begin
        a_sel[i] = a_el[elem_idx(2'(i), d[1:0])];
        b_sel[i] = b_el[elem_idx(d[1:0], 2'(i))];
      end
    end
  end

  assign a1 = a_sel[0];
  assign a2 = a_sel[1];
  assign a3 = a_sel[2];
  assign b1 = b_sel[0];
  assign b2 = b_sel[1];
  assign b3 = b_sel[2];

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for the 3x3 output-stationary systolic array: latch, clear, feed, drain, capture.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned data_size = 32,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [9*data_size-1:0] a_mat,
  input  logic [9*data_size-1:0] b_mat,
  output logic                   busy,
  output logic                   done,
  output logic [9*data_size-1:0] c_mat,
  output logic                   arr_rst,
  output logic [data_size-1:0]   arr_a1,
  output logic [data_size-1:0]   arr_a2,
  output logic [data_size-1:0]   arr_a3,
  output logic [data_size-1:0]   arr_b1,
  output logic [data_size-1:0]   arr_b2,
  output logic [data_size-1:0]   arr_b3,
  input  logic [data_size-1:0]   arr_c1,
  input  logic [data_size-1:0]   arr_c2,
  input  logic [data_size-1:0]   arr_c3,
  input  logic [data_size-1:0]   arr_c4,
  input  logic [data_size-1:0]   arr_c5,
  input  logic [data_size-1:0]   arr_c6,
  input  logic [data_size-1:0]   arr_c7,
  input  logic [data_size-1:0]   arr_c8,
  input  logic [data_size-1:0]   arr_c9
);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [9*data_size-1:0] a_lat_q, a_lat_d, b_lat_q, b_lat_d, c_q, c_d;
  logic                   busy_q, busy_d, done_q, done_d, arr_rst_q, arr_rst_d;
  logic [data_size-1:0]   arr_a_q [SaN];
  logic [data_size-1:0]   arr_b_q [SaN];
  logic [data_size-1:0]   arr_a_d [SaN];
  logic [data_size-1:0]   arr_b_d [SaN];
  logic [data_size-1:0]   sel_a   [SaN];
  logic [data_size-1:0]   sel_b   [SaN];
  logic                   feed_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_lat_d   = a_lat_q;
    b_lat_d   = b_lat_q;
    c_d       = c_q;
    done_d    = 1'b0;
    arr_rst_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StClear;
          a_lat_d   = a_mat;
          b_lat_d   = b_mat;
          arr_rst_d = 1'b1;
        end
      end
      StClear: begin
        state_d = StFeed;
        cnt_d   = '0;
      end
      StFeed: begin
        if (cnt_q == 4'(SaFeedCyc - 1)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDrain: begin
        if (cnt_q == 4'(DRAIN_CYC - 1)) begin
          state_d = StCapture;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StCapture: begin
        state_d = StIdle;
        c_d     = {arr_c9, arr_c8, arr_c7, arr_c6, arr_c5, arr_c4, arr_c3, arr_c2, arr_c1};
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Outputs are registered, so the selector looks at the step being entered.
  assign feed_en = (state_d == StFeed);

  systolic_ctrl_skew_sel #(
    .data_size(data_size)
  ) u_skew_sel (
    .k    (cnt_d),
    .a_mat(a_lat_q),
    .b_mat(b_lat_q),
    .a1   (sel_a[0]),
    .a2   (sel_a[1]),
    .a3   (sel_a[2]),
    .b1   (sel_b[0]),
    .b2   (sel_b[1]),
    .b3   (sel_b[2])
  );

  always_comb begin
    for (int i = 0; i < int'(SaN); i++) begin
      arr_a_d[i] = feed_en ? sel_a[i] : '0;
      arr_b_d[i] = feed_en ? sel_b[i] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_lat_q   <= '0;
      b_lat_q   <= '0;
      c_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      arr_rst_q <= 1'b0;
      for (int i = 0; i < int'(SaN); i++) begin
        arr_a_q[i] <= '0;
        arr_b_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_lat_q   <= a_lat_d;
      b_lat_q   <= b_lat_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      arr_rst_q <= arr_rst_d;
      for (int i = 0; i < int'(SaN); i++) begin
        arr_a_q[i] <= arr_a_d[i];
        arr_b_q[i] <= arr_b_d[i];
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign c_mat   = c_q;
  assign arr_rst = arr_rst_q;
  assign arr_a1  = arr_a_q[0];
  assign arr_a2  = arr_a_q[1];
  assign arr_a3  = arr_a_q[2];
  assign arr_b1  = arr_b_q[0];
  assign arr_b2  = arr_b_q[1];
  assign arr_b3  = arr_b_q[2];

endmodule
